apb4_slave_mem_bridge: RTL and testbench

Parametrised APB4 completer bridging one APB4 port to a single-ported SRAM-style memory with a request/ready command handshake and a read-valid return.
Next generation of the team's APB slave SRAM interface. Adds:
- real wait states via PREADY
- byte strobes sized DATA_WIDTH/8
- address-range and PPROT checking with PSLVERR
- a read-return timeout
Sits between the APB4 interconnect and on-chip memory macros.

---
 rtl/apb4_slave_mem_bridge.sv | 185 ++++++++++++++++++
 tb/tb_apb4_slave_mem_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_slave_mem_bridge.sv
// APB4 completer in front of a single-ported SRAM-style memory: request/ready command
// handshake, read-valid return, range/protection decode errors and a bounded wait.
module apb4_slave_mem_bridge #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter bit          SECURE_ONLY = 1'b0,
    parameter int unsigned RD_TIMEOUT  = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [2:0]            PPROT,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    output logic                  mem_req,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write,
    output logic [STRB_WIDTH-1:0] mem_strb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StMemReq, StRdWait, StResp} state_e;

    localparam int unsigned           OffW       = $clog2(STRB_WIDTH);
    localparam int unsigned           AddrLimit  = MEM_DEPTH * STRB_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] AddrMask   = ~ADDR_WIDTH'((1 << OffW) - 1);
    localparam logic [7:0]            TimeoutVal = 8'(RD_TIMEOUT);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    abort_q, abort_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_write_q, mem_write_d;
    logic [STRB_WIDTH-1:0]   mem_strb_q, mem_strb_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic                    decode_err;
    logic                    drop;
    logic                    done;
    logic                    err;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [31:0]             paddr_ext;
    logic                    unused_prot;

    assign paddr_ext   = 32'(PADDR);
    assign decode_err  = (paddr_ext >= AddrLimit) || (SECURE_ONLY && PPROT[1]);
    assign drop        = abort_q || !PSEL;
    assign unused_prot = ^{PPROT[2], PPROT[0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = '0;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        mem_strb_d  = mem_strb_q;
        mem_wdata_d = mem_wdata_q;
        done        = 1'b0;
        err         = 1'b0;
        rdata       = '0;

        unique case (state_q)
            StIdle: begin
                if (PSEL && !PENABLE) begin
                    if (decode_err) begin
                        state_d   = StResp;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d     = StMemReq;
                        cnt_d       = '0;
                        abort_d     = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = PADDR & AddrMask;
                        mem_write_d = PWRITE;
                        mem_strb_d  = PWRITE ? PSTRB : '0;
                        mem_wdata_d = PWDATA;
                    end
                end
            end
            StMemReq: begin
                cnt_d   = cnt_q + 8'd1;
                abort_d = drop;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_write_q) begin
                        done = 1'b1;
                    end else begin
                        state_d = StRdWait;
                    end
                end else if (cnt_d >= TimeoutVal) begin
                    mem_req_d = 1'b0;
                    done      = 1'b1;
                    err       = 1'b1;
                end
            end
            StRdWait: begin
                cnt_d   = cnt_q + 8'd1;
                abort_d = drop;
                if (mem_rvalid) begin
                    done  = 1'b1;
                    rdata = mem_rdata;
                end else if (cnt_d >= TimeoutVal) begin
                    done = 1'b1;
                    err  = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A transfer abandoned by the requester finishes its memory side silently.
        if (done) begin
            if (drop) begin
                state_d = StIdle;
            end else begin
                state_d   = StResp;
                pready_d  = 1'b1;
                pslverr_d = err;
                prdata_d  = rdata;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_strb_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            prdata_q    <= prdata_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_strb_q  <= mem_strb_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign PRDATA    = prdata_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_strb  = mem_strb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_apb4_slave_mem_bridge.sv
// Directed bench for apb4_slave_mem_bridge (SECURE_ONLY=1, defaults otherwise);
// outputs are sampled 1 ns after each rising edge.
module tb_apb4_slave_mem_bridge;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 12;
    localparam int unsigned SW = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic [AW-1:0] PADDR;
    logic [2:0]    PPROT;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;
    logic          mem_req;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [SW-1:0] mem_strb;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb4_slave_mem_bridge #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (256),
        .SECURE_ONLY(1'b1),
        .RD_TIMEOUT (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PADDR     (PADDR),
        .PPROT     (PPROT),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_strb  (mem_strb),
        .mem_wdata (mem_wdata),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a setup phase, lets the edge sample it, then moves to the access phase.
    task automatic setup(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strb, input logic [2:0] prot);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        PSTRB   = strb;
        PPROT   = prot;
        tick();
        PENABLE = 1'b1;
    endtask

    // Called while PREADY is high: completes the access and checks the response clears.
    task automatic finish_xfer(input string tag);
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        check({tag, "_pready_clr"}, PREADY, 1'b0);
        check({tag, "_pslverr_clr"}, PSLVERR, 1'b0);
        check({tag, "_prdata_clr"}, PRDATA, 32'h0);
    endtask

    task automatic normal_write(input string tag, input logic [AW-1:0] addr,
                                input logic [AW-1:0] exp_addr, input logic [DW-1:0] wdata,
                                input logic [SW-1:0] strb, input logic [2:0] prot);
        setup(1'b1, addr, wdata, strb, prot);
        check({tag, "_req"}, mem_req, 1'b1);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_strb"}, mem_strb, strb);
        check({tag, "_wr"}, mem_write, 1'b1);
        check({tag, "_wdata"}, mem_wdata, wdata);
        check({tag, "_wait"}, PREADY, 1'b0);
        tick();
        check({tag, "_pready"}, PREADY, 1'b1);
        check({tag, "_pslverr"}, PSLVERR, 1'b0);
        check({tag, "_req_drop"}, mem_req, 1'b0);
        finish_xfer(tag);
    endtask

    task automatic normal_read(input string tag, input logic [AW-1:0] addr,
                               input logic [AW-1:0] exp_addr, input logic [DW-1:0] rdata);
        setup(1'b0, addr, 32'hFFFF_FFFF, 4'hF, 3'b000);
        check({tag, "_req"}, mem_req, 1'b1);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_strb"}, mem_strb, 4'h0);
        check({tag, "_wr"}, mem_write, 1'b0);
        // Stray rvalid while the command is still pending must not be taken.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        tick();
        check({tag, "_wait"}, PREADY, 1'b0);
        check({tag, "_req_drop"}, mem_req, 1'b0);
        mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
        check({tag, "_pready"}, PREADY, 1'b1);
        check({tag, "_pslverr"}, PSLVERR, 1'b0);
        check({tag, "_prdata"}, PRDATA, rdata);
        finish_xfer(tag);
    endtask

    initial begin
        int n;
        PRESETn    = 1'b0;
        PADDR      = '0;
        PPROT      = '0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        PWRITE     = 1'b0;
        PWDATA     = '0;
        PSTRB      = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();
        check("rst_pready", PREADY, 1'b0);
        check("rst_pslverr", PSLVERR, 1'b0);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_req", mem_req, 1'b0);
        check("rst_wr", mem_write, 1'b0);
        check("rst_addr", mem_addr, 12'h0);
        check("rst_strb", mem_strb, 4'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        PRESETn = 1'b1;
        tick();

        // Basic write and read (each is back-to-back with the previous transfer)
        normal_write("wr1", 12'h010, 12'h010, 32'hDEAD_BEEF, 4'b0101, 3'b000);
        normal_read("rd1", 12'h013, 12'h010, 32'h1234_5678);
        normal_write("wr_nostrb", 12'h02E, 12'h02C, 32'h5555_AAAA, 4'b0000, 3'b000);
        normal_read("rd_last", 12'h3FC, 12'h3FC, 32'hA5A5_5A5A);

        // Out-of-range read: zero wait states, error, no command
        setup(1'b0, 12'h400, 32'h0, 4'h0, 3'b000);
        check("oor_pready", PREADY, 1'b1);
        check("oor_pslverr", PSLVERR, 1'b1);
        check("oor_prdata", PRDATA, 32'h0);
        check("oor_req", mem_req, 1'b0);
        finish_xfer("oor");

        // Non-secure write rejected; secure variants accepted
        setup(1'b1, 12'h020, 32'h0102_0304, 4'hF, 3'b010);
        check("ns_pready", PREADY, 1'b1);
        check("ns_pslverr", PSLVERR, 1'b1);
        check("ns_req", mem_req, 1'b0);
        finish_xfer("ns");
        normal_write("sec0", 12'h020, 12'h020, 32'h0102_0304, 4'hF, 3'b000);
        normal_write("sec5", 12'h024, 12'h024, 32'h0A0B_0C0D, 4'b1000, 3'b101);

        // Read return never arrives
        setup(1'b0, 12'h004, 32'h0, 4'h0, 3'b000);
        check("to_wait0", PREADY, 1'b0);
        n = 0;
        while (PREADY !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("to_latency", n, 16);
        check("to_pslverr", PSLVERR, 1'b1);
        check("to_prdata", PRDATA, 32'h0);
        check("to_req", mem_req, 1'b0);
        finish_xfer("to");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_CAFE;
        tick();
        mem_rvalid = 1'b0;
        check("late_rv_pready", PREADY, 1'b0);
        check("late_rv_prdata", PRDATA, 32'h0);
        normal_write("post_to", 12'h030, 12'h030, 32'hFEED_F00D, 4'hF, 3'b000);

        // Memory stalls, then asynchronous reset mid-wait
        mem_ready = 1'b0;
        setup(1'b1, 12'h040, 32'h1122_3344, 4'hF, 3'b000);
        check("stall_req0", mem_req, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_req", mem_req, 1'b1);
            check("stall_addr", mem_addr, 12'h040);
            check("stall_pready", PREADY, 1'b0);
        end
        #2;
        PRESETn = 1'b0;
        #1;
        check("arst_req", mem_req, 1'b0);
        check("arst_pready", PREADY, 1'b0);
        check("arst_addr", mem_addr, 12'h0);
        check("arst_wr", mem_write, 1'b0);
        #1;
        PRESETn   = 1'b1;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("arst_idle_req", mem_req, 1'b0);
        normal_read("post_rst", 12'h008, 12'h008, 32'h0BAD_F00D);

        // Requester abandons a write: handshake completes, no PREADY
        mem_ready = 1'b0;
        setup(1'b1, 12'h050, 32'h7777_8888, 4'hF, 3'b000);
        check("abw_req", mem_req, 1'b1);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        tick();
        check("abw_req_hold", mem_req, 1'b1);
        check("abw_pready0", PREADY, 1'b0);
        mem_ready = 1'b1;
        tick();
        check("abw_req_done", mem_req, 1'b0);
        check("abw_pready1", PREADY, 1'b0);
        tick();
        check("abw_pready2", PREADY, 1'b0);

        // Requester abandons a read: return data discarded
        setup(1'b0, 12'h054, 32'h0, 4'h0, 3'b000);
        tick();
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h3333_4444;
        tick();
        mem_rvalid = 1'b0;
        check("abr_pready", PREADY, 1'b0);
        check("abr_prdata", PRDATA, 32'h0);
        tick();
        check("abr_pready2", PREADY, 1'b0);

        // Access phase without a preceding setup is ignored
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 12'h060;
        tick();
        check("noset_req", mem_req, 1'b0);
        check("noset_pready", PREADY, 1'b0);
        tick();
        check("noset_req2", mem_req, 1'b0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        tick();
        normal_read("final", 12'h0F1, 12'h0F0, 32'h600D_CAFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary, observed hang expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
